// File: rtl/clock_display_scan_pkg.sv
// Shared types, segment codes and digit helpers for the clock display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package clock_display_scan_pkg;

  localparam int N_DIG = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  localparam logic [7:0] MAX_SEC  = 8'd59;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_HR24 = 8'd23;
  localparam logic [7:0] MAX_HR12 = 8'd12;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hr;
    logic       fmt24;
  } time_t;

  localparam time_t TIME_RESET = '{sec: 8'd0, min: 8'd0, hr: 8'd0, fmt24: 1'b1};

  typedef enum logic [1:0] {
    DSEL_DIGIT = 2'd0,
    DSEL_BLANK = 2'd1,
    DSEL_DASH  = 2'd2
  } seg_sel_e;

  // Tens digit by compare chain; only meaningful for v <= 59.
  function automatic logic [3:0] tens_of(input logic [7:0] v);
    logic [3:0] t;
    if (v >= 8'd50) begin
      t = 4'd5;
    end else if (v >= 8'd40) begin
      t = 4'd4;
    end else if (v >= 8'd30) begin
      t = 4'd3;
    end else if (v >= 8'd20) begin
      t = 4'd2;
    end else if (v >= 8'd10) begin
      t = 4'd1;
    end else begin
      t = 4'd0;
    end
    return t;
  endfunction

  function automatic logic [3:0] units_of(input logic [7:0] v);
    logic [7:0] prod;
    prod = {4'd0, tens_of(v)} * 8'd10;
    return 4'(v - prod);
  endfunction

  function automatic logic time_err(input time_t t);
    logic hr_bad;
    if (t.fmt24) begin
      hr_bad = (t.hr > MAX_HR24);
    end else begin
      hr_bad = (t.hr == 8'd0) || (t.hr > MAX_HR12);
    end
    return (t.sec > MAX_SEC) || (t.min > MAX_MIN) || hr_bad;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment code, with blank and dash overrides.
module seg7_decode
  import clock_display_scan_pkg::*;
(
  input  logic [3:0] digit,
  input  seg_sel_e   sel,
  output logic [6:0] seg
);

  logic [6:0] digit_seg_s;

  // Plain digit lookup; non-decimal codes stay dark.
  always_comb begin
    digit_seg_s = SEG_BLANK;
    case (digit)
      4'd0:    digit_seg_s = SEG_0;
      4'd1:    digit_seg_s = SEG_1;
      4'd2:    digit_seg_s = SEG_2;
      4'd3:    digit_seg_s = SEG_3;
      4'd4:    digit_seg_s = SEG_4;
      4'd5:    digit_seg_s = SEG_5;
      4'd6:    digit_seg_s = SEG_6;
      4'd7:    digit_seg_s = SEG_7;
      4'd8:    digit_seg_s = SEG_8;
      4'd9:    digit_seg_s = SEG_9;
      default: digit_seg_s = SEG_BLANK;
    endcase
  end

  // Override select.
  always_comb begin
    seg = SEG_BLANK;
    case (sel)
      DSEL_DIGIT: seg = digit_seg_s;
      DSEL_DASH:  seg = SEG_DASH;
      DSEL_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Captures time fields on Valid, commits them once per frame and scans them
// onto a 6-digit common-anode seven-segment display.
module clock_display_scan
  import clock_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             Valid,
  input  logic [7:0]       seconds,
  input  logic [7:0]       mins,
  input  logic [7:0]       hrs,
  input  logic             i_time_format,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [N_DIG-1:0] an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]    presc_r;
  logic [2:0]       idx_r;
  time_t            pend_r;
  time_t            shad_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [N_DIG-1:0] an_r;

  logic             slot_end_s;
  logic             frame_end_s;
  logic             err_s;
  logic [7:0]       field_s;
  logic [3:0]       digit_s;
  seg_sel_e         sel_s;
  logic [6:0]       dec_seg_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;
  logic [N_DIG-1:0] an_nxt_s;

  assign slot_end_s  = (presc_r == PRESC_LAST);
  assign frame_end_s = slot_end_s && (idx_r == DIG_HR_T);

  // Prescaler and digit index.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= 3'd0;
    end else if (slot_end_s) begin
      presc_r <= '0;
      idx_r   <= (idx_r == DIG_HR_T) ? 3'd0 : idx_r + 3'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Pending capture (last Valid wins) and frame-boundary commit to shadow;
  // the commit reads the old pending, so a same-cycle Valid waits a frame.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= TIME_RESET;
      shad_r <= TIME_RESET;
    end else begin
      if (Valid) begin
        pend_r <= '{sec: seconds, min: mins, hr: hrs, fmt24: i_time_format};
      end
      if (frame_end_s) begin
        shad_r <= pend_r;
      end
    end
  end

  assign err_s = time_err(shad_r);

  // Field select and decimal split for the current digit.
  always_comb begin
    field_s = shad_r.sec;
    case (idx_r)
      DIG_SEC_U, DIG_SEC_T: field_s = shad_r.sec;
      DIG_MIN_U, DIG_MIN_T: field_s = shad_r.min;
      DIG_HR_U,  DIG_HR_T:  field_s = shad_r.hr;
      default:              field_s = shad_r.sec;
    endcase
    if (idx_r[0]) begin
      digit_s = tens_of(field_s);
    end else begin
      digit_s = units_of(field_s);
    end
  end

  // Dash on error, suppressed leading hour zero in 12h mode.
  always_comb begin
    sel_s = DSEL_DIGIT;
    if (err_s) begin
      sel_s = DSEL_DASH;
    end else if ((idx_r == DIG_HR_T) && !shad_r.fmt24 && (digit_s == 4'd0)) begin
      sel_s = DSEL_BLANK;
    end else begin
      sel_s = DSEL_DIGIT;
    end
  end

  seg7_decode u_dec (
    .digit (digit_s),
    .sel   (sel_s),
    .seg   (dec_seg_s)
  );

  // Next output value; the first cycle of each slot is blanked against ghosting.
  always_comb begin
    seg_nxt_s = SEG_BLANK;
    dp_nxt_s  = 1'b1;
    an_nxt_s  = '1;
    if (presc_r == '0) begin
      seg_nxt_s = SEG_BLANK;
      dp_nxt_s  = 1'b1;
      an_nxt_s  = '1;
    end else begin
      seg_nxt_s = dec_seg_s;
      an_nxt_s  = ~({{(N_DIG-1){1'b0}}, 1'b1} << idx_r);
      if (err_s) begin
        dp_nxt_s = 1'b1;
      end else if ((idx_r == DIG_MIN_U) || (idx_r == DIG_HR_U)) begin
        dp_nxt_s = 1'b0;
      end else begin
        dp_nxt_s = 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      an_r  <= '1;
    end else begin
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: a cycle model pushes the expected
// output of every edge into a queue that is popped and compared after the edge.
module tb_clock_display_scan;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 6 * SCAN_DIV;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b1;
  logic       Valid = 1'b0;
  logic [7:0] seconds = 8'd0;
  logic [7:0] mins = 8'd0;
  logic [7:0] hrs = 8'd0;
  logic       i_time_format = 1'b1;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks = 0;
  int failures = 0;

  // Model state
  int m_p, m_i;
  int p_sec, p_min, p_hr;
  bit p_f24;
  int s_sec, s_min, s_hr;
  bit s_f24;
  logic [13:0] exp_q[$];
  int an_cnt[6];

  clock_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .Valid         (Valid),
    .seconds       (seconds),
    .mins          (mins),
    .hrs           (hrs),
    .i_time_format (i_time_format),
    .seg           (seg),
    .dp            (dp),
    .an            (an)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] expect_out(input int p, input int i, input int sec,
                                             input int mn, input int hr, input bit f24);
    logic [5:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    int v, d;
    bit err;
    if (p == 0) return {7'h7F, 1'b1, 6'h3F};
    an_e = 6'h3F;
    an_e[i] = 1'b0;
    err = (sec > 59) || (mn > 59) || (f24 ? (hr > 23) : (hr == 0 || hr > 12));
    v = (i < 2) ? sec : (i < 4) ? mn : hr;
    d = (i % 2 == 1) ? v / 10 : v % 10;
    seg_e = seg_of(d);
    if (i == 5 && !f24 && d == 0) seg_e = 7'h7F;
    dp_e = (i == 2 || i == 4) ? 1'b0 : 1'b1;
    if (err) begin
      seg_e = 7'b0111111;
      dp_e = 1'b1;
    end
    return {seg_e, dp_e, an_e};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_i = 0;
    p_sec = 0; p_min = 0; p_hr = 0; p_f24 = 1'b1;
    s_sec = 0; s_min = 0; s_hr = 0; s_f24 = 1'b1;
    exp_q.delete();
  endtask

  task automatic tick();
    logic [13:0] e;
    exp_q.push_back(expect_out(m_p, m_i, s_sec, s_min, s_hr, s_f24));
    @(posedge CLK);
    if (m_p == SCAN_DIV - 1 && m_i == 5) begin
      s_sec = p_sec; s_min = p_min; s_hr = p_hr; s_f24 = p_f24;
    end
    if (Valid) begin
      p_sec = int'(seconds); p_min = int'(mins); p_hr = int'(hrs); p_f24 = i_time_format;
    end
    if (m_p == SCAN_DIV - 1) begin
      m_p = 0;
      m_i = (m_i == 5) ? 0 : m_i + 1;
    end else begin
      m_p++;
    end
    #1;
    e = exp_q.pop_front();
    check("seg", {1'b0, seg}, {1'b0, e[13:7]});
    check("dp", {7'd0, dp}, {7'd0, e[6]});
    check("an", {2'd0, an}, {2'd0, e[5:0]});
    for (int k = 0; k < 6; k++) begin
      if (an == ~(6'b000001 << k)) an_cnt[k]++;
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n * FRAME; k++) tick();
  endtask

  task automatic pulse(input int s, input int m, input int h, input bit f);
    seconds = 8'(s); mins = 8'(m); hrs = 8'(h); i_time_format = f;
    Valid = 1'b1;
    tick();
    Valid = 1'b0;
    seconds = 8'($urandom); mins = 8'($urandom); hrs = 8'($urandom);
    i_time_format = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    check({tag, "_dp"}, {7'd0, dp}, 8'd1);
    check({tag, "_an"}, {2'd0, an}, 8'h3F);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    @(posedge CLK);
    @(posedge CLK);
    #1 check_reset_outputs("rst_hold");
    #1 rst_n = 1'b1;

    // Idle scan with junk on the inputs; Valid low so nothing is captured.
    seconds = 8'd11; mins = 8'd22; hrs = 8'd7; i_time_format = 1'b0;
    for (int k = 0; k < 6; k++) an_cnt[k] = 0;
    frames(24);
    for (int k = 0; k < 6; k++) check($sformatf("an_cnt%0d", k), 8'(an_cnt[k]), 8'(24 * (SCAN_DIV - 1)));

    pulse(56, 34, 12, 1'b1); frames(2);
    pulse(7, 5, 9, 1'b0);    frames(2);
    pulse(7, 5, 9, 1'b1);    frames(2);

    // Out-of-range times, then recovery
    pulse(0, 0, 24, 1'b1);   frames(2);
    pulse(0, 60, 1, 1'b1);   frames(2);
    pulse(0, 0, 0, 1'b0);    frames(2);
    pulse(0, 0, 13, 1'b0);   frames(2);
    pulse(56, 34, 12, 1'b1); frames(2);

    // Three Valids inside one frame
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (m_i == 1) break;
      tick();
    end
    check("align_idx1", {7'd0, m_i == 1}, 8'd1);
    pulse(0, 0, 1, 1'b1);
    pulse(0, 0, 2, 1'b1);
    pulse(0, 0, 3, 1'b1);
    frames(2);

    // Valid in the commit cycle appears one frame later
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (m_p == SCAN_DIV - 1 && m_i == 5) break;
      tick();
    end
    check("align_commit", {7'd0, m_p == SCAN_DIV - 1 && m_i == 5}, 8'd1);
    pulse(45, 30, 4, 1'b1);
    frames(2);

    // Valid held high
    seconds = 8'd59; mins = 8'd59; hrs = 8'd23; i_time_format = 1'b1;
    Valid = 1'b1;
    frames(2);
    Valid = 1'b0;
    frames(1);

    // Reset in the middle of a frame
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (m_i == 3 && m_p == 2) break;
      tick();
    end
    check("align_mid", {7'd0, m_i == 3}, 8'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    @(posedge CLK);
    #1 check_reset_outputs("rst_mid_hold");
    #1 rst_n = 1'b1;
    frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
